// File: rtl/debounce_sync.sv
// rtl/debounce_sync.sv - synchronizer plus debounce FSM with edge pulses and a saturating glitch counter
module debounce_sync #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int GLITCH_W        = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                din_async,
    input  logic                clr_glitch,
    output logic                dout,
    output logic                rise,
    output logic                fall,
    output logic                busy,
    output logic [GLITCH_W-1:0] glitch_cnt
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    // cnt holds samples already taken, so the accepting sample is the one seen at DEBOUNCE_CYCLES-1
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_LO  = 2'd0,
        CHK_HI = 2'd1,
        ST_HI  = 2'd2,
        CHK_LO = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [SYNC_STAGES-1:0]  sync_q, sync_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    dout_q, dout_d;
    logic                    rise_q, rise_d;
    logic                    fall_q, fall_d;
    logic                    busy_q, busy_d;
    logic [GLITCH_W-1:0]     glitch_q, glitch_d;
    logic                    abort;
    logic                    s;

    assign s = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], din_async};
        state_d  = state_q;
        cnt_d    = cnt_q;
        dout_d   = dout_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        abort    = 1'b0;
        glitch_d = glitch_q;

        case (state_q)
            ST_LO: begin
                if (s) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_d = ST_HI;
                        dout_d  = 1'b1;
                        rise_d  = 1'b1;
                    end else begin
                        state_d = CHK_HI;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            CHK_HI: begin
                if (!s) begin
                    state_d = ST_LO;
                    cnt_d   = '0;
                    abort   = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_HI;
                    cnt_d   = '0;
                    dout_d  = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_HI: begin
                if (!s) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_d = ST_LO;
                        dout_d  = 1'b0;
                        fall_d  = 1'b1;
                    end else begin
                        state_d = CHK_LO;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            CHK_LO: begin
                if (s) begin
                    state_d = ST_HI;
                    cnt_d   = '0;
                    abort   = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_LO;
                    cnt_d   = '0;
                    dout_d  = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_LO;
                cnt_d   = '0;
            end
        endcase

        busy_d = (state_d == CHK_HI) || (state_d == CHK_LO);

        // clear beats a simultaneous abort; the counter sticks at all-ones
        if (clr_glitch) begin
            glitch_d = '0;
        end else if (abort && (glitch_q != {GLITCH_W{1'b1}})) begin
            glitch_d = glitch_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= '0;
            state_q  <= ST_LO;
            cnt_q    <= '0;
            dout_q   <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            busy_q   <= 1'b0;
            glitch_q <= '0;
        end else begin
            sync_q   <= sync_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dout_q   <= dout_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            busy_q   <= busy_d;
            glitch_q <= glitch_d;
        end
    end

    assign dout       = dout_q;
    assign rise       = rise_q;
    assign fall       = fall_q;
    assign busy       = busy_q;
    assign glitch_cnt = glitch_q;

endmodule
